// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the five-stage MIPS core.
//
// Captures decoded operands, immediate, register addresses and control bits
// from ID on every rising edge, and adds:
//   - a valid bit travelling with the instruction,
//   - external hold (ext_stall) and squash (flush),
//   - load-use hazard detection with automatic one-cycle bubble insertion,
//   - a precomputed branch target and destination register,
//   - a saturating count of inserted load-use bubbles.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   id_*                       decoded instruction currently in ID
//   flush                      squash the instruction entering EX
//   ext_stall                  downstream busy, hold EX contents
//   ex_*                       registered EX-stage copies / derived fields
//   hazard_stall               load-use detected (combinational)
//   stall_if_id                freeze PC and IF/ID (hazard_stall | ext_stall)
//   bubble_cnt                 load-use bubbles inserted, saturating
//
// Pipeline control, evaluated every cycle in this priority order:
//   flush        -> EX becomes a bubble (valid, control and datapath all 0)
//   ext_stall    -> EX holds every field, including ex_valid
//   hazard_stall -> EX becomes a bubble and bubble_cnt increments
//   otherwise    -> EX loads ID (control bits forced to 0 when !id_valid)
// IF/ID is expected to hold whenever stall_if_id is high, so the dependent
// instruction is presented again on the cycle after its bubble.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int FUNC_W  = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_rd1,
    input  logic [DATA_W-1:0]  id_rd2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  id_pc_plus4,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [FUNC_W-1:0]  id_func,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic               id_reg_dst,
    input  logic               id_alu_src,
    input  logic [2:0]         id_alu_op,
    input  logic               flush,
    input  logic               ext_stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_rd1,
    output logic [DATA_W-1:0]  ex_rd2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc_plus4,
    output logic [DATA_W-1:0]  ex_branch_target,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_dest,
    output logic [FUNC_W-1:0]  ex_func,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic [2:0]         ex_alu_op,
    output logic               hazard_stall,
    output logic               stall_if_id,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // Control bits packed as {reg_write, mem_to_reg, mem_read, mem_write,
    //                         branch, jump, reg_dst, alu_src}
    localparam int CTRL_W = 8;

    logic               r_valid;
    logic [DATA_W-1:0]  r_rd1;
    logic [DATA_W-1:0]  r_rd2;
    logic [DATA_W-1:0]  r_imm;
    logic [DATA_W-1:0]  r_pc_plus4;
    logic [DATA_W-1:0]  r_branch_target;
    logic [RADDR_W-1:0] r_rs;
    logic [RADDR_W-1:0] r_rt;
    logic [RADDR_W-1:0] r_dest;
    logic [FUNC_W-1:0]  r_func;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [2:0]         r_alu_op;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic [CTRL_W-1:0]  w_ctrl_in;
    logic [2:0]         w_alu_op_in;
    logic [DATA_W-1:0]  w_branch_target;
    logic [RADDR_W-1:0] w_dest;
    logic               w_hazard;
    logic               w_rt_match;

    // An instruction that is not valid must never carry live control bits
    // into EX, otherwise it could write the register file or memory.
    assign w_ctrl_in   = id_valid ? {id_reg_write, id_mem_to_reg, id_mem_read,
                                     id_mem_write, id_branch, id_jump,
                                     id_reg_dst, id_alu_src}
                                  : '0;
    assign w_alu_op_in = id_valid ? id_alu_op : 3'b000;

    // Word offset shifted into a byte offset; the top two immediate bits fall
    // off and the sum wraps modulo 2^DATA_W.
    assign w_branch_target = id_pc_plus4 + {id_imm[DATA_W-3:0], 2'b00};
    assign w_dest          = id_reg_dst ? id_rd : id_rt;

    // Load in EX whose destination is read by the instruction in ID. $0 is
    // hardwired to zero so it can never be a real dependency. A flushed ID
    // instruction is discarded anyway, so it does not need a bubble.
    assign w_rt_match   = (r_rt == id_rs) || (r_rt == id_rt);
    assign w_hazard     = r_valid && r_ctrl[5] && (r_rt != '0) && id_valid &&
                          w_rt_match && !flush;
    assign hazard_stall = w_hazard;
    assign stall_if_id  = w_hazard || ext_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid         <= 1'b0;
            r_rd1           <= '0;
            r_rd2           <= '0;
            r_imm           <= '0;
            r_pc_plus4      <= '0;
            r_branch_target <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_dest          <= '0;
            r_func          <= '0;
            r_ctrl          <= '0;
            r_alu_op        <= 3'b000;
            r_bubble_cnt    <= '0;
        end else if (flush || (!ext_stall && w_hazard)) begin
            // Bubble: flush wins over a hold so a squashed instruction can
            // never survive a downstream stall.
            r_valid         <= 1'b0;
            r_rd1           <= '0;
            r_rd2           <= '0;
            r_imm           <= '0;
            r_pc_plus4      <= '0;
            r_branch_target <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_dest          <= '0;
            r_func          <= '0;
            r_ctrl          <= '0;
            r_alu_op        <= 3'b000;
            // Only load-use bubbles are counted, never flush bubbles.
            if (!flush && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else if (!ext_stall) begin
            r_valid         <= id_valid;
            r_rd1           <= id_rd1;
            r_rd2           <= id_rd2;
            r_imm           <= id_imm;
            r_pc_plus4      <= id_pc_plus4;
            r_branch_target <= w_branch_target;
            r_rs            <= id_rs;
            r_rt            <= id_rt;
            r_dest          <= w_dest;
            r_func          <= id_func;
            r_ctrl          <= w_ctrl_in;
            r_alu_op        <= w_alu_op_in;
        end
    end

    assign ex_valid         = r_valid;
    assign ex_rd1           = r_rd1;
    assign ex_rd2           = r_rd2;
    assign ex_imm           = r_imm;
    assign ex_pc_plus4      = r_pc_plus4;
    assign ex_branch_target = r_branch_target;
    assign ex_rs            = r_rs;
    assign ex_rt            = r_rt;
    assign ex_dest          = r_dest;
    assign ex_func          = r_func;
    assign ex_reg_write     = r_ctrl[7];
    assign ex_mem_to_reg    = r_ctrl[6];
    assign ex_mem_read      = r_ctrl[5];
    assign ex_mem_write     = r_ctrl[4];
    assign ex_branch        = r_ctrl[3];
    assign ex_jump          = r_ctrl[2];
    assign ex_reg_dst       = r_ctrl[1];
    assign ex_alu_src       = r_ctrl[0];
    assign ex_alu_op        = r_alu_op;
    assign bubble_cnt       = r_bubble_cnt;

endmodule
